seq_detect_moore: RTL
=====================

# seq_detect_moore

Parametrised Moore-style serial pattern detector. It generalises the team's fixed four-state Moore FSM to an arbitrary PATTERN_W-bit target pattern, selectable overlapping or non-overlapping detection, sample qualification, and a saturating match counter. It sits on a serial bit stream and flags each completed occurrence of the pattern to downstream control logic.

## Interface
- PATTERN_W, 4, pattern length in bits; legal range 2–16.
- PATTERN, 4'b1011, target pattern; bit PATTERN_W-1 is the first bit received.
- OVERLAP, 1, 1 = overlapping detection, 0 = non-overlapping.
- CNT_W, 8, width of match_count.

Ports:
- clk  in  1  rising-edge clock; the block has a single clock.
- rst_n  in  1  asynchronous, active-low reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only on cycles where this is 1.
- clear  in  1  synchronous clear of the state and the counter.
- z  out  1  Moore output; 1 while the FSM is in the MATCH state.
- state  out  SW  current state index, where SW = $clog2(PATTERN_W+1).
- match_count  out  CNT_W  number of matches, saturating.

## Operation
- States are S0..S(PATTERN_W):
  - Sk means the first k pattern bits have been matched.
  - S(PATTERN_W) is MATCH.
- Next state on a sampled bit b from Sk (k < PATTERN_W):
  - Take the string (first k pattern bits) followed by b.
  - The next state is the largest j ≤ PATTERN_W such that the last j bits of that string equal the first j pattern bits.
  - This is the KMP failure transition, computed at elaboration time.
- From MATCH:
  - OVERLAP=1: apply the same rule with k = PATTERN_W.
  - OVERLAP=0: transition as if from S0.
- z = (state == MATCH).
  - z is a registered-state decode only; it never depends combinationally on x.
- match_count increments by 1 on every transition into MATCH.
  - This includes MATCH→MATCH, which is possible in overlap mode when the pattern is all ones or all zeros.
  - It holds at 2^CNT_W-1; there is no wrap-around.
- x_valid=0: state and count hold. z stays 1 if the FSM is held in MATCH.
- Priority, highest first: rst_n low, then clear, then x_valid.
  - clear → state S0 and count 0 on the next edge, regardless of x_valid.
- Any out-of-range state encoding recovers to S0 on the next clock edge.

## Timing
- Reset values: state = S0, z = 0, match_count = 0.
  - Asserting rst_n low forces these values immediately and asynchronously, including mid-pattern.
  - Deassertion is synchronised externally.
- Latency:
  - Final pattern bit sampled at edge N → z = 1 after edge N.
  - match_count updates at that same edge N.
- z stays high for one cycle per match when x_valid is held high.
- Back-to-back overlapping matches keep z high continuously; the count advances on each match.
- clear and a final matching bit in the same cycle: clear wins. z stays 0 and the count becomes 0.

## Structure
- Package seq_detect_pkg holds:
  - function next_state(pattern, width, k, b, overlap), used to build the transition table at elaboration;
  - the state-width helper.
- Sub-module seq_match_counter: saturating counter with inc, clr and CNT_W parameter.
- The FSM state register and table lookup stay in the top module.

## Test plan
- Reset: hold rst_n=0 mid-pattern, then release → state=0, z=0, match_count=0 immediately and after release.
- OVERLAP=1, PATTERN=1011, stream 1,0,1,1,0,1,1 (x_valid=1) → z=1 after the 4th and 7th bits only; match_count=2.
- OVERLAP=0, same stream → z=1 after the 4th bit only; match_count=1.
- x_valid gaps: the same 1011 with x_valid=0 for 3 cycles between bits → a single match on the last valid bit; state holds during the gaps.
- PATTERN=1111 with OVERLAP=1, stream of six 1s → z high from the 4th bit through the 6th; match_count=3.
  - With CNT_W=2 and a longer stream, match_count saturates at 3.
- clear asserted on the cycle the final 1 of 1011 arrives → z stays 0, match_count=0, state=0.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and elaboration-time helpers for the serial pattern detector.
package seq_detect_pkg;

  // What the FSM does on a given clock edge.
  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_STEP    = 2'd1,
    ACT_CLEAR   = 2'd2,
    ACT_RECOVER = 2'd3
  } fsm_act_t;

  localparam int MAX_PATTERN_W = 16;

  // Bits needed to hold state indices 0..pattern_w.
  function automatic int state_width(input int pattern_w);
    return $clog2(pattern_w + 1);
  endfunction

  // KMP transition: from Sk on bit b, the longest prefix of the pattern that
  // is a suffix of (first k pattern bits, b). From MATCH without overlap the
  // detector restarts as if from S0.
  function automatic int next_state(input logic [15:0] pattern, input int width,
                                    input int k, input bit b, input bit overlap);
    logic [16:0] str;
    int          kk;
    int          lim;
    int          best;
    kk   = (k >= width && !overlap) ? 0 : k;
    str  = 17'(pattern) >> (width - kk);
    str  = {str[15:0], b};
    lim  = (kk + 1 > width) ? width : kk + 1;
    best = 0;
    for (int j = 1; j <= MAX_PATTERN_W; j++) begin
      if (j <= lim && ((str & ((17'd1 << j) - 17'd1)) == (17'(pattern) >> (width - j))))
        best = j;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detect_moore_if.sv
// Serial-stream and status signals between a bit source and the detector.
interface seq_detect_moore_if #(
  parameter int SW    = 3,
  parameter int CNT_W = 8
);
  logic             x;
  logic             x_valid;
  logic             clear;
  logic             z;
  logic [SW-1:0]    state;
  logic [CNT_W-1:0] match_count;

  modport master (output x, x_valid, clear, input z, state, match_count);
  modport slave  (input x, x_valid, clear, output z, state, match_count);
endinterface

// File: rtl/seq_match_counter.sv
// Saturating event counter with synchronous clear.
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  // Clear beats increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_reg <= '0;
    else if (clr)
      count_reg <= '0;
    else if (inc && (count_reg != '1))
      count_reg <= count_reg + CNT_W'(1);
  end

  assign count = count_reg;

endmodule

// File: rtl/seq_detect_moore.sv
// Moore serial pattern detector: KMP transition table built at elaboration,
// registered state and z, plus a saturating match counter.
module seq_detect_moore
  import seq_detect_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input logic               clk,
  input logic               rst_n,
  seq_detect_moore_if.slave bus
);

  localparam int            SW       = state_width(PATTERN_W);
  localparam int            NS       = PATTERN_W + 1;
  localparam logic [SW-1:0] MATCH_ST = SW'(PATTERN_W);

  logic [SW-1:0] next_tbl [NS][2];
  logic [SW-1:0] state_reg;
  logic          z_reg;
  logic [SW-1:0] step_state;
  fsm_act_t      act;
  logic          enter_match;

  for (genvar gi = 0; gi < NS; gi++) begin : g_state
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      localparam int NXT = next_state(16'(PATTERN), PATTERN_W, gi, (gb != 0), OVERLAP);
      assign next_tbl[gi][gb] = SW'(NXT);
    end
  end

  // Table lookup for the current state and incoming bit.
  always_comb begin
    step_state = '0;
    for (int i = 0; i < NS; i++) begin
      if (state_reg == SW'(i))
        step_state = next_tbl[i][bus.x];
    end
  end

  // Edge action: clear first, then illegal-state recovery, then sampling.
  always_comb begin
    act = ACT_HOLD;
    if (bus.clear)
      act = ACT_CLEAR;
    else if (state_reg > MATCH_ST)
      act = ACT_RECOVER;
    else if (bus.x_valid)
      act = ACT_STEP;
  end

  assign enter_match = (act == ACT_STEP) && (step_state == MATCH_ST);

  // State register with z registered alongside so it decodes MATCH only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      z_reg     <= 1'b0;
    end else begin
      case (act)
        ACT_CLEAR, ACT_RECOVER: begin
          state_reg <= '0;
          z_reg     <= 1'b0;
        end
        ACT_STEP: begin
          state_reg <= step_state;
          z_reg     <= (step_state == MATCH_ST);
        end
        default: begin
          state_reg <= state_reg;
          z_reg     <= z_reg;
        end
      endcase
    end
  end

  seq_match_counter #(.CNT_W(CNT_W)) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (enter_match),
    .clr   (act == ACT_CLEAR),
    .count (bus.match_count)
  );

  assign bus.z     = z_reg;
  assign bus.state = state_reg;

endmodule
